// File: rtl/median_avg_reader.sv
// Sweeps the DEPTH-entry median buffer over RAM port B and outputs the floor mean of its entries.
// Latency: start_i sampled at edge N -> avg_valid_o in cycle N+DEPTH+2; one extra request can queue, further ones raise overrun_o.
module median_avg_reader #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8,
   parameter int AW     = 3
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   output logic [AW-1:0]     addr_o,
   output logic              rd_en_o,
   input  logic [DATA_W-1:0] rd_data_i,
   output logic [DATA_W-1:0] avg_o,
   output logic              avg_valid_o,
   output logic              busy_o,
   output logic              overrun_o
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   state_t                 state, state_nxt;
   logic [DATA_W+AW-1:0]   acc;
   logic [DATA_W+AW-1:0]   sum;
   logic                   pending;

   assign sum         = acc + {{AW{1'b0}}, rd_data_i};
   assign rd_en_o     = (state == READ);
   assign busy_o      = (state != IDLE);
   assign avg_valid_o = (state == DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_i || pending) state_nxt = READ;
         READ:    if (addr_o == LAST) state_nxt = DRAIN;
         DRAIN:   state_nxt = DONE;
         DONE:    state_nxt = pending ? READ : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         addr_o    <= '0;
         avg_o     <= '0;
         acc       <= '0;
         pending   <= 1'b0;
         overrun_o <= 1'b0;
      end else begin
         state <= state_nxt;

         // A queued request that launches from IDLE frees the slot; a same-cycle start_i refills it.
         if (state == IDLE) begin
            pending <= pending & start_i;
         end else begin
            if (start_i && pending) overrun_o <= 1'b1;
            if (state == DONE && pending) pending <= 1'b0;
            else if (start_i && !pending) pending <= 1'b1;
         end

         case (state)
            IDLE: begin
               acc    <= '0;
               addr_o <= '0;
            end
            READ: begin
               // Read data lags the address by one cycle, so the first address contributes nothing yet.
               if (addr_o != '0) acc <= sum;
               if (addr_o != LAST) addr_o <= addr_o + 1'b1;
            end
            DRAIN: begin
               acc   <= sum;
               avg_o <= DATA_W'(sum >> AW);
            end
            DONE: begin
               acc    <= '0;
               addr_o <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_median_avg_reader.sv
// Drives median_avg_reader against a synchronous-read RAM model; a monitor checks each result against a queue of expected averages.
module tb_median_avg_reader;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  addr;
   logic        rd_en;
   logic [15:0] rd_data;
   logic [15:0] avg;
   logic        avg_valid;
   logic        busy;
   logic        overrun;

   logic [15:0] mem [8];
   logic [15:0] exp_q [$];
   int          total;
   int          bad;

   median_avg_reader #(.DATA_W(16), .DEPTH(8), .AW(3)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .addr_o     (addr),
      .rd_en_o    (rd_en),
      .rd_data_i  (rd_data),
      .avg_o      (avg),
      .avg_valid_o(avg_valid),
      .busy_o     (busy),
      .overrun_o  (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[addr];
   end

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (avg_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got %0d want none", avg);
         end else begin
            chk("avg", avg, int'(exp_q.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input logic [15:0] v);
      for (int i = 0; i < 8; i++) mem[i] = v;
   endtask

   task automatic pulse();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60 && busy; i++) tick();
      chk("idle_timeout", int'(busy), 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_addr"}, int'(addr), 0);
      chk({tag, "_rd_en"}, int'(rd_en), 0);
      chk({tag, "_avg"}, int'(avg), 0);
      chk({tag, "_avg_valid"}, int'(avg_valid), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_overrun"}, int'(overrun), 0);
   endtask

   initial begin
      int s;
      total   = 0;
      bad     = 0;
      rst     = 1'b1;
      start   = 1'b0;
      rd_data = '0;
      fill(16'd0);
      #12;
      chk_zero("reset");
      @(posedge clk);
      #1 rst = 1'b0;

      // Single sweep timing, all entries 100
      fill(16'd100);
      exp_q.push_back(16'd100);
      pulse();
      for (int c = 1; c <= 11; c++) begin
         if (c <= 8) begin
            chk("t1_addr", int'(addr), c - 1);
            chk("t1_rd_en", int'(rd_en), 1);
            chk("t1_busy", int'(busy), 1);
         end
         if (c == 9) begin
            chk("t1_drain_rd_en", int'(rd_en), 0);
            chk("t1_drain_addr", int'(addr), 7);
         end
         chk("t1_avg_valid", int'(avg_valid), (c == 10) ? 1 : 0);
         if (c == 11) begin
            chk("t1_busy_end", int'(busy), 0);
            chk("t1_addr_end", int'(addr), 0);
         end
         tick();
      end

      // Floor division and full-scale entries
      for (int i = 0; i < 8; i++) mem[i] = 16'(i);
      exp_q.push_back(16'd3);
      pulse();
      wait_idle();
      fill(16'hFFFF);
      exp_q.push_back(16'hFFFF);
      pulse();
      wait_idle();

      // One queued request, RAM content changes between sweeps
      fill(16'd100);
      exp_q.push_back(16'd100);
      exp_q.push_back(16'd20);
      for (int c = 0; c <= 21; c++) begin
         if (c == 10) chk("t3_valid1", int'(avg_valid), 1);
         if (c == 11) begin
            chk("t3_addr_restart", int'(addr), 0);
            chk("t3_rd_en_restart", int'(rd_en), 1);
         end
         if (c == 19) chk("t3_valid_gap", int'(avg_valid), 0);
         if (c == 20) chk("t3_valid2", int'(avg_valid), 1);
         if (c == 10) fill(16'd20);
         start = (c == 0 || c == 4);
         tick();
      end
      start = 1'b0;
      wait_idle();
      chk("t3_overrun", int'(overrun), 0);

      // Third request while one is already queued is dropped
      fill(16'd40);
      exp_q.push_back(16'd40);
      exp_q.push_back(16'd40);
      for (int c = 0; c <= 22; c++) begin
         if (c == 5) chk("t4_overrun_pre", int'(overrun), 0);
         if (c == 6 || c == 15 || c == 22) chk("t4_overrun_sticky", int'(overrun), 1);
         if (c == 10 || c == 20) chk("t4_valid", int'(avg_valid), 1);
         start = (c == 0 || c == 3 || c == 5);
         tick();
      end
      start = 1'b0;
      wait_idle();
      chk("t4_overrun_end", int'(overrun), 1);

      // Asynchronous reset mid-sweep aborts without a result
      fill(16'd60);
      pulse();
      for (int c = 1; c < 5; c++) tick();
      chk("t5_busy_before", int'(busy), 1);
      rst = 1'b1;
      #1;
      chk_zero("t5_async");
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) mem[i] = 16'(10 * (i + 1));
      exp_q.push_back(16'd45);
      pulse();
      wait_idle();

      // Random RAM contents, expected mean from the bench's own sum
      for (int n = 0; n < 10; n++) begin
         s = 0;
         for (int i = 0; i < 8; i++) begin
            mem[i] = 16'($urandom_range(0, 65535));
            s += int'(mem[i]);
         end
         exp_q.push_back(16'(s / 8));
         pulse();
         wait_idle();
         repeat ($urandom_range(0, 3)) tick();
      end

      repeat (5) tick();
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/median_avg_reader.md
Name: median_avg_reader

Overview:
- Read-side counterpart to the median write FSM: consumes the write FSM's buffer-full pulse, reads the whole DEPTH-entry median buffer from the block RAM read port, and produces the arithmetic mean of the entries.
- Sits between the block RAM port B and the averaging output. It is the hardware alternative to the PicoBlaze read path and drives the same avg result.

Parameters:
- DATA_W, 16, width of each median sample stored in RAM.
- DEPTH, 8, number of entries averaged; must be a power of 2 and at least 2.
- AW, 3, RAM address width; must equal log2(DEPTH).

Ports:
- clk_i  input  1  system clock; all logic is on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  single-cycle pulse from the write FSM meaning the buffer is full (its control_rd).
- addr_o  output  AW  RAM port B read address.
- rd_en_o  output  1  RAM read enable; high while addr_o is valid.
- rd_data_i  input  DATA_W  RAM port B read data; synchronous read, 1-cycle latency.
- avg_o  output  DATA_W  last computed average; held until the next result.
- avg_valid_o  output  1  one-cycle pulse when avg_o updates.
- busy_o  output  1  high whenever the state is not IDLE.
- overrun_o  output  1  sticky; set when start_i arrives while a request is already pending; cleared only by reset.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - addr_o=0, rd_en_o=0, avg_o=0, avg_valid_o=0, busy_o=0, overrun_o=0.
  - Accumulator, counters and pending flag are cleared.
  - Reset asserted mid-operation aborts the sweep immediately: no avg_valid_o pulse, and avg_o returns to 0.
- Accumulator width is DATA_W+AW (19 bits by default). This width cannot overflow: DEPTH*(2^DATA_W-1) fits.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start_i=1 -> READ. Accumulator cleared; addr_o=0, rd_en_o=1 on entry.
- READ:
  - addr_o increments by 1 each cycle through 0..DEPTH-1, with rd_en_o=1.
  - Each cycle (except the first) adds rd_data_i, i.e. the data for the previous address.
  - When addr_o=DEPTH-1 -> DRAIN.
- DRAIN (1 cycle):
  - rd_en_o=0 and addr_o holds DEPTH-1.
  - Adds the final rd_data_i (entry DEPTH-1) -> DONE.
- DONE (1 cycle):
  - avg_o = accumulator >> AW. This is floor division; the discarded low bits are truncated with no rounding.
  - avg_valid_o=1 this cycle only.
  - Next state is READ if the pending flag is set (the flag is cleared on that transition), else IDLE.
- Latency: start_i high at edge N gives addr_o=0 at cycle N+1, avg_valid_o at cycle N+DEPTH+2 (cycle 10 for DEPTH=8).
- Back-to-back: a pending restart gives a fresh sweep with addr_o=0 in the cycle after DONE. Result pulses are spaced DEPTH+2 cycles apart.
- start_i while busy (READ/DRAIN/DONE):
  - If the pending flag is clear, it is set.
  - If it is already set, the request is dropped and overrun_o is set.
  - The current sweep is never disturbed.
- start_i held high for several cycles is treated as one request per cycle sampled. The bench and the write FSM must pulse it for one cycle.
- Addresses are always swept 0..DEPTH-1 in order with no wrap-around. addr_o returns to 0 in IDLE.
- rd_data_i is ignored outside READ and DRAIN.

Test Plan:
- Reset, then preload all 8 entries = 100, pulse start_i at cycle 0 -> addr_o 0..7 on cycles 1..8, rd_en_o high on cycles 1..8, avg_o=100 with avg_valid_o high on cycle 10 only; busy_o low from cycle 11.
- Entries 0,1,..,7 (sum 28) -> avg_o=3 (floor of 3.5); entries all 0xFFFF -> avg_o=0xFFFF, showing no accumulator overflow.
- Pulse start_i at cycle 0 and again at cycle 4 with a new RAM content of all 20 -> first result 100 at cycle 10, second sweep addr_o=0 at cycle 11, avg_o=20 at cycle 20, overrun_o stays 0.
- Pulse start_i at cycles 0, 3 and 5 -> one pending request serviced, third dropped, overrun_o=1 from cycle 6 onward.
- Assert rst_i at cycle 5 of a sweep -> all outputs 0 asynchronously, no avg_valid_o pulse; a new start_i after release produces a correct full result.
- Random start_i pulses against a random RAM content, checked by a scoreboard -> every avg_o equals floor(sum/8) of the RAM content at sweep time.
